// File: rtl/if_fetch_unit_if.sv
// Signal bundle between the fetch unit and its environment: hazard/redirect
// controls, the instruction-memory ready/valid handshake and the IF/ID outputs.
interface if_fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic [31:0] instruction;
    logic [31:0] instru_addr_plus4;
    logic        fetch_valid;

    modport master (
        input  stall, redirect, redirect_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output instruction, instru_addr_plus4, fetch_valid
    );

    modport slave (
        output stall, redirect, redirect_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  instruction, instru_addr_plus4, fetch_valid
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one memory read in flight and
// holds the returned word in a one-entry buffer that feeds the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;

    logic        can_issue;
    logic        req;
    logic        handshake;
    logic        show_buf;

    // A request may only go out when the buffer is guaranteed to be free by
    // the time the response lands, which keeps exactly one word in flight.
    assign can_issue = !buf_valid_q || !bus.stall;
    assign req       = rst_n && (state_q == S_REQ) && can_issue && !bus.redirect;
    assign handshake = req && bus.imem_ready;
    assign show_buf  = buf_valid_q && !bus.redirect;

    assign bus.imem_req          = req;
    assign bus.imem_addr         = pc_q;
    assign bus.instruction       = show_buf ? buf_inst_q : NOP;
    assign bus.fetch_valid       = show_buf;
    assign bus.instru_addr_plus4 = (show_buf ? buf_pc_q : pc_q) + 32'd4;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_inst_d  = buf_inst_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;

        if (buf_valid_q && !bus.stall) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (handshake) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    buf_inst_d  = bus.imem_rdata;
                    buf_pc_d    = req_pc_q;
                    buf_valid_d = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // A response arriving in the redirect cycle retires the old request,
        // so only a still-pending read needs to be dropped later.
        if (bus.redirect) begin
            pc_d        = {bus.redirect_addr[31:2], 2'b00};
            buf_valid_d = 1'b0;
            if (state_q == S_WAIT || state_q == S_DROP) begin
                state_d = bus.imem_rvalid ? S_REQ : S_DROP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            buf_inst_q  <= NOP;
            buf_pc_q    <= RESET_PC;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_inst_q  <= buf_inst_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios, a per-cycle
// behavioural model of the fetch stream, and literal checks on the logged stream.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_unit_if bus();

    if_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Behavioural view: where the PC is, what word sits in the buffer, and
    // whether a read is in flight whose data must be thrown away.
    logic [31:0] mPc       = RESET_PC;
    logic [31:0] mBufWord  = NOP;
    logic [31:0] mBufAddr  = RESET_PC;
    logic [31:0] mBusyAddr = RESET_PC;
    bit          mBufValid = 1'b0;
    bit          mBusy     = 1'b0;
    bit          mDiscard  = 1'b0;

    bit          pendValid = 1'b0;
    logic [31:0] pendData  = 32'h0;

    logic [31:0] reqLog[$];
    logic [31:0] fetchInst[$];
    logic [31:0] fetchPlus4[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit expReq();
        return (rst_n === 1'b1) && !mBusy && (!mBufValid || !bus.stall) && !bus.redirect;
    endfunction

    task automatic updateModel();
        bit hs;
        if (rst_n !== 1'b1) begin
            mPc       = RESET_PC;
            mBufValid = 1'b0;
            mBusy     = 1'b0;
            mDiscard  = 1'b0;
        end else begin
            hs = expReq() && bus.imem_ready;
            if (mBufValid && !bus.stall) mBufValid = 1'b0;
            if (mBusy && bus.imem_rvalid) begin
                mBusy = 1'b0;
                if (!mDiscard) begin
                    mBufValid = 1'b1;
                    mBufWord  = mBusyAddr ^ KEY;
                    mBufAddr  = mBusyAddr;
                end
            end
            if (hs) begin
                mBusy     = 1'b1;
                mBusyAddr = mPc;
                mPc       = mPc + 32'd4;
                mDiscard  = 1'b0;
            end
            if (bus.redirect) begin
                mPc       = bus.redirect_addr & ~32'd3;
                mBufValid = 1'b0;
                if (mBusy) mDiscard = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive inputs, act as a 1-cycle memory (optionally
    // holding back its response), then advance the model at the edge.
    task automatic applyStimulus(input bit rstV, input bit stallV, input bit redirV,
                                 input logic [31:0] raddr, input bit readyV, input bit holdV);
        rst_n             = rstV;
        bus.stall         = stallV;
        bus.redirect      = redirV;
        bus.redirect_addr = raddr;
        bus.imem_ready    = readyV;
        if (pendValid && !holdV) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pendData;
            pendValid       = 1'b0;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
        @(negedge clk);
        if (bus.imem_req === 1'b1 && bus.imem_ready) begin
            pendValid = 1'b1;
            pendData  = bus.imem_addr ^ KEY;
        end
        @(posedge clk);
        updateModel();
        #1;
    endtask

    always @(negedge clk) begin
        bit showBuf;
        if (checkEn) begin
            showBuf = mBufValid && !bus.redirect;
            checkOutput("imem_req", {31'b0, bus.imem_req}, {31'b0, expReq()});
            if (expReq()) checkOutput("imem_addr", bus.imem_addr, mPc);
            checkOutput("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, showBuf});
            checkOutput("instruction", bus.instruction, showBuf ? mBufWord : NOP);
            checkOutput("instru_addr_plus4", bus.instru_addr_plus4, (showBuf ? mBufAddr : mPc) + 32'd4);
            if (rst_n === 1'b1 && bus.imem_req === 1'b1 && bus.imem_ready) reqLog.push_back(bus.imem_addr);
            if (bus.fetch_valid === 1'b1 && !bus.stall) begin
                fetchInst.push_back(bus.instruction);
                fetchPlus4.push_back(bus.instru_addr_plus4);
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        bus.stall         = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'h0;
        bus.imem_ready    = 1'b1;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = 32'h0;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("reset_imem_req", {31'b0, bus.imem_req}, 32'd0);
        checkOutput("reset_instruction", bus.instruction, 32'h0000_0000);
        checkOutput("reset_plus4", bus.instru_addr_plus4, 32'h0000_0004);
        checkOutput("reset_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);

        $display("[TB] free-running fetch");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] stall with full buffer");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
            if (i == 2) begin
                checkOutput("stall_instruction", bus.instruction, 32'hA5A5_000C);
                checkOutput("stall_plus4", bus.instru_addr_plus4, 32'h0000_0010);
                checkOutput("stall_imem_req", {31'b0, bus.imem_req}, 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] redirect while waiting on memory");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] memory not ready");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] redirect to top of address space");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] reset with a read in flight");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checkEn = 1'b0;

        checkOutput("req_count", 32'(reqLog.size()), 32'd16);
        checkOutput("req_after_redirect", reqLog[6], 32'h0000_0100);
        checkOutput("req_after_not_ready", reqLog[8], 32'h0000_0108);
        checkOutput("req_pc_once", reqLog[9], 32'h0000_010C);
        checkOutput("req_wrap_top", reqLog[10], 32'hFFFF_FFFC);
        checkOutput("req_wrap_zero", reqLog[11], 32'h0000_0000);
        checkOutput("req_after_reset", reqLog[13], 32'h0000_0000);
        checkOutput("fetch_count", 32'(fetchInst.size()), 32'd12);
        checkOutput("fetch0_inst", fetchInst[0], 32'hA5A5_0000);
        checkOutput("fetch0_plus4", fetchPlus4[0], 32'h0000_0004);
        checkOutput("fetch1_inst", fetchInst[1], 32'hA5A5_0004);
        checkOutput("fetch2_plus4", fetchPlus4[2], 32'h0000_000C);
        checkOutput("fetch3_inst", fetchInst[3], 32'hA5A5_000C);
        checkOutput("fetch4_inst", fetchInst[4], 32'hA5A5_0010);
        checkOutput("fetch5_inst", fetchInst[5], 32'hA5A5_0100);
        checkOutput("fetch5_plus4", fetchPlus4[5], 32'h0000_0104);
        checkOutput("fetch8_inst", fetchInst[8], 32'h5A5A_FFFC);
        checkOutput("fetch8_plus4", fetchPlus4[8], 32'h0000_0000);
        checkOutput("fetch10_inst", fetchInst[10], 32'hA5A5_0000);
        checkOutput("fetch10_plus4", fetchPlus4[10], 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that drives the IF/ID pipeline register. It owns the program counter and issues single-outstanding read requests to instruction memory over a ready/valid handshake. Each returned word is held in a one-entry buffer and presented as `instruction` / `instru_addr_plus4` to the IF/ID register. The unit honours the hazard unit's `stall` and the ID stage's branch/jump `redirect`, and presents a NOP bubble whenever no valid instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP`, 32'h0000_0000, word presented when no valid instruction is available (sll $0,$0,0)

- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  synchronous, active-low reset, sampled on posedge `clk`
- `stall`  in  1  IF/ID hold; same signal that drives the IF/ID register
- `redirect`  in  1  branch/jump taken in ID; flush and reload PC
- `redirect_addr`  in  32  new PC; bits [1:0] forced to 0
- `imem_req`  out  1  read request valid
- `imem_addr`  out  32  word address of request (PC)
- `imem_ready`  in  1  memory accepts request when `imem_req && imem_ready`
- `imem_rvalid`  in  1  read data valid; not back-pressurable
- `imem_rdata`  in  32  read data
- `instruction`  out  32  to IF/ID `instruction`
- `instru_addr_plus4`  out  32  to IF/ID `instru_addr_plus4`
- `fetch_valid`  out  1  `instruction` is a real fetched word, not a bubble

## Operation
- Registers: `pc`, `req_pc`, `buf_inst`, `buf_pc`, `buf_valid`, 2-bit FSM `state`.
- Reset (`rst_n`=0 at posedge): `pc`=RESET_PC, `buf_valid`=0, `state`=S_REQ. All outputs then read `imem_req`=0 (in the reset cycle), `instruction`=NOP, `instru_addr_plus4`=RESET_PC+4, `fetch_valid`=0. Reset mid-transaction abandons the outstanding request. Any `imem_rvalid` after reset is ignored until a new request is accepted.
- The buffer is consumed at a posedge when `buf_valid && !stall`.
- `can_issue` = `!buf_valid || !stall`.
- FSM states:
  - S_REQ:
    - `imem_req` = `can_issue && !redirect`, and `imem_addr` = `pc`.
    - On handshake: `req_pc`<=`pc`, `pc`<=`pc`+4 (mod 2^32), go to S_WAIT.
  - S_WAIT:
    - On `imem_rvalid`: `buf_inst`<=`imem_rdata`, `buf_pc`<=`req_pc`, `buf_valid`<=1, go to S_REQ.
  - S_DROP:
    - On `imem_rvalid`: discard the data, go to S_REQ.
- Redirect (highest priority, ignores `stall`):
  - `pc`<=`redirect_addr` & ~3, `buf_valid`<=0.
  - If a request is outstanding (S_WAIT, or a handshake would occur this cycle), go to S_DROP. `imem_req` is suppressed in the redirect cycle, so no handshake occurs.
  - Combinationally, `instruction`=NOP and `fetch_valid`=0 during the redirect cycle, so IF/ID captures a bubble.
- A redirect while already in S_DROP updates `pc` only and stays in S_DROP.
- Outputs: `instruction` = (`buf_valid && !redirect`) ? `buf_inst` : NOP. `instru_addr_plus4` = `buf_pc`+4 when valid, else `pc`+4. `fetch_valid` mirrors the `instruction` select.
- Buffer capacity guarantee: issue only when `can_issue`, with a single request outstanding. A response therefore always finds the buffer empty, and no data is lost.
- Consumption and response in the same cycle: the buffer is consumed and reloaded at that edge (`buf_valid` stays 1).

## Timing
- Best-case loop: request accepted in cycle N, `imem_rvalid` earliest in N+1, instruction visible in N+2. Throughput is one instruction per 2 cycles with 1-cycle memory.
- `imem_req` may deassert while `imem_ready` is low only due to redirect or stall. `imem_addr` holds while `imem_req` stays high.
- `stall` held: `instruction`, `instru_addr_plus4` and `fetch_valid` stay stable; at most one further request is issued (buffer empty case) and then the unit waits.
- `pc`+4 and `buf_pc`+4 wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000.

## Test plan
- Reset, 1-cycle memory returning addr-dependent data (`imem_rdata`=addr^32'hA5A5_0000), no stall. Required response: addresses 0,4,8,… requested in order; IF/ID sees words for 0,4,8 with `instru_addr_plus4`=4,8,12; a bubble (NOP) between each.
- `stall`=1 for 5 cycles with the buffer full. Required response: outputs frozen, no `imem_req`. On release: the same word is consumed once, and the next address follows.
- `redirect`=1, `redirect_addr`=32'h0000_0103 while in S_WAIT. Required response: redirect cycle output NOP / `fetch_valid`=0; the late response is discarded; the next request is to 32'h0000_0100.
- `imem_ready` low for 3 cycles. Required response: `imem_req`/`imem_addr` stable until the handshake; `pc` increments only once.
- PC wrap: `redirect_addr`=32'hFFFF_FFFC. Required response: fetch at FFFF_FFFC with `instru_addr_plus4`=0, then a request at 0.
- Assert `rst_n`=0 while in S_WAIT, then return `imem_rvalid` after reset. Required response: the data is ignored, outputs at reset values, first request to RESET_PC.
